// File: rtl/uart_rx_if.sv
// Signal bundle between the UART receiver and its consumer.
// The consumer drives the serial line in loopback; the receiver drives the byte outputs.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       rx_frame_err;

    modport master (
        output rx,
        input  rx_data, rx_valid, rx_busy, rx_frame_err
    );

    modport slave (
        input  rx,
        output rx_data, rx_valid, rx_busy, rx_frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver that times each bit with a down-counter of DIV clocks per bit.
// Defining UART_RX_MAJORITY_EN enables a 3-sample majority vote at each sample point.
module uart_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int          DIV         = CLK_FREQ / BAUD;
    localparam logic [20:0] FULL_RELOAD = 21'(DIV - 1);
    localparam logic [20:0] HALF_RELOAD = 21'(DIV / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      state, state_n;
    logic [20:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shift, shift_n;
    logic [7:0]  data_q, data_n;
    logic        valid_q, valid_n;
    logic        busy_q, busy_n;
    logic        ferr_q, ferr_n;
    logic        rx_meta, rx_s;
    logic        rx_v;
    logic        sample;

    // Both synchronizer flops reset high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // vote[0] holds rx_s from cnt==1, vote[1] from cnt==2; the live rx_s is the cnt==0 vote.
    logic [1:0] vote;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote <= 2'b11;
        end else begin
            vote <= {vote[0], rx_s};
        end
    end

    assign rx_v = (vote[1] & vote[0]) | (vote[1] & rx_s) | (vote[0] & rx_s);
`else
    assign rx_v = rx_s;
`endif

    assign sample = (cnt == 21'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 21'd0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            busy_q  <= busy_n;
            ferr_q  <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        data_n    = data_q;
        valid_n   = 1'b0;
        busy_n    = busy_q;
        ferr_n    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_n = S_START;
                    cnt_n   = HALF_RELOAD;
                    busy_n  = 1'b1;
                end
            end
            S_START: begin
                if (!sample) begin
                    cnt_n = cnt - 21'd1;
                end else if (rx_v) begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                end else begin
                    state_n   = S_DATA;
                    cnt_n     = FULL_RELOAD;
                    bit_idx_n = 3'd0;
                end
            end
            S_DATA: begin
                if (!sample) begin
                    cnt_n = cnt - 21'd1;
                end else begin
                    shift_n   = {rx_v, shift[7:1]};
                    cnt_n     = FULL_RELOAD;
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (!sample) begin
                    cnt_n = cnt - 21'd1;
                end else if (rx_v) begin
                    data_n  = shift;
                    valid_n = 1'b1;
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                end else begin
                    ferr_n  = 1'b1;
                    state_n = S_BREAK;
                end
            end
            S_BREAK: begin
                // Wait for the line to go idle so a held-low break cannot retrigger.
                if (rx_s) begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign bus.rx_data      = data_q;
    assign bus.rx_valid     = valid_q;
    assign bus.rx_busy      = busy_q;
    assign bus.rx_frame_err = ferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIV=10: frame-level model plus directed scenarios.
module tb_uart_rx;
    localparam int DIV     = 10;
    localparam int DUE_OFS = 3 + DIV / 2 + 9 * DIV;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         due;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_data = 8'h00;
    evt_t       exp_q[$];
    evt_t       cmp_evt;
    int         valid_count = 0;
    int         err_count = 0;
    int         last_valid_cyc = 0;
    int         last_err_cyc = 0;
    logic [7:0] last_valid_data = 8'h00;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_FREQ(1_000_000),
        .BAUD    (100_000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycle(input int n);
        while (cyc < n) tick();
        @(negedge clk);
    endtask

    // Sends one full frame; glitch is the frame bit index (0=start, 1..8 data) whose centre gets inverted for one clock.
    task automatic applyStimulus(input logic [7:0] data, input logic stop, input int glitch, output int start_cyc);
        logic [9:0] frame;
        logic [7:0] model;
        logic       b;
        evt_t       e;
        frame = {stop, data, 1'b0};
        model = data;
`ifndef UART_RX_MAJORITY_EN
        if (glitch >= 1 && glitch <= 8) model[glitch-1] = ~model[glitch-1];
`endif
        start_cyc = cyc;
        e.is_err  = !stop;
        e.data    = model;
        e.due     = cyc + DUE_OFS;
        exp_q.push_back(e);
        for (int c = 0; c < 10 * DIV; c++) begin
            b = frame[c/DIV];
            if (c == glitch * DIV + DIV / 2) b = ~b;
            bus.rx = b;
            tick();
        end
    endtask

    // Frame-level model: every expected pulse is due 2 sync + 1 detect + 9.5 bit times after the start edge.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            exp_data = 8'h00;
            checkOutput("reset_outputs", {bus.rx_data, bus.rx_valid, bus.rx_busy, bus.rx_frame_err}, 0);
        end else begin
            checkOutput("valid_err_exclusive", bus.rx_valid & bus.rx_frame_err, 0);
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                cmp_evt = exp_q.pop_front();
                checkOutput("pulse_kind", {bus.rx_valid, bus.rx_frame_err}, cmp_evt.is_err ? 2'b01 : 2'b10);
                if (!cmp_evt.is_err) exp_data = cmp_evt.data;
            end else begin
                checkOutput("no_pulse", {bus.rx_valid, bus.rx_frame_err}, 0);
            end
            checkOutput("rx_data", bus.rx_data, exp_data);
            if (bus.rx_valid) begin
                valid_count++;
                last_valid_cyc  = cyc;
                last_valid_data = bus.rx_data;
                checkOutput("busy_low_on_valid", bus.rx_busy, 0);
            end
            if (bus.rx_frame_err) begin
                err_count++;
                last_err_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s, k, v0, e0;
        bus.rx = 1'b1;
        rst    = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        checkOutput("idle_busy", bus.rx_busy, 0);

        $display("[TB] single byte 8'hA5");
        v0 = valid_count;
        applyStimulus(8'hA5, 1'b1, -1, s);
        repeat (5) tick();
        checkOutput("a5_count", valid_count - v0, 1);
        checkOutput("a5_data", last_valid_data, 8'hA5);
        checkOutput("a5_latency", last_valid_cyc - s, 98);
        checkOutput("a5_no_err", err_count, 0);

        $display("[TB] reset mid-frame");
        v0 = valid_count;
        for (int c = 0; c < 4 * DIV; c++) begin
            bus.rx = (c < DIV) ? 1'b0 : ((c / DIV) % 2 == 1);
            tick();
        end
        checkOutput("busy_mid_frame", bus.rx_busy, 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_outputs", {bus.rx_data, bus.rx_valid, bus.rx_busy, bus.rx_frame_err}, 0);
        bus.rx = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        checkOutput("post_rst_busy", bus.rx_busy, 0);
        checkOutput("post_rst_no_pulse", valid_count - v0, 0);

        $display("[TB] false start");
        v0 = valid_count;
        k = cyc;
        bus.rx = 1'b0;
        tick();
        tick();
        waitCycle(k + 2);
        checkOutput("fs_busy_before", bus.rx_busy, 0);
        tick();
        bus.rx = 1'b1;
        waitCycle(k + 3);
        checkOutput("fs_busy_rise", bus.rx_busy, 1);
        waitCycle(k + 7);
        checkOutput("fs_busy_hold", bus.rx_busy, 1);
        waitCycle(k + 8);
        checkOutput("fs_busy_fall", bus.rx_busy, 0);
        repeat (15) tick();
        checkOutput("fs_no_valid", valid_count - v0, 0);

        $display("[TB] back-to-back loopback");
        v0 = valid_count;
        applyStimulus(8'h00, 1'b1, -1, s);
        k = s;
        applyStimulus(8'hFF, 1'b1, -1, s);
        applyStimulus(8'h55, 1'b1, -1, s);
        applyStimulus(8'h80, 1'b1, -1, s);
        repeat (5) tick();
        checkOutput("lb_count", valid_count - v0, 4);
        checkOutput("lb_last_data", last_valid_data, 8'h80);
        checkOutput("lb_last_cycle", last_valid_cyc - k, 398);
        checkOutput("lb_no_err", err_count, 0);

        $display("[TB] framing error");
        e0 = err_count;
        v0 = valid_count;
        applyStimulus(8'h3C, 1'b0, -1, s);
        repeat (30) tick();
        checkOutput("fe_count", err_count - e0, 1);
        checkOutput("fe_cycle", last_err_cyc - s, 98);
        checkOutput("fe_data_kept", bus.rx_data, 8'h80);
        checkOutput("fe_busy_held", bus.rx_busy, 1);
        checkOutput("fe_no_valid", valid_count - v0, 0);
        bus.rx = 1'b1;
        k = cyc;
        waitCycle(k + 2);
        checkOutput("break_busy_hold", bus.rx_busy, 1);
        waitCycle(k + 3);
        checkOutput("break_busy_fall", bus.rx_busy, 0);
        tick();
        applyStimulus(8'h11, 1'b1, -1, s);
        repeat (5) tick();
        checkOutput("after_fe_data", last_valid_data, 8'h11);
        checkOutput("after_fe_count", valid_count - v0, 1);

        $display("[TB] glitch on data bit 3");
        applyStimulus(8'h00, 1'b1, 4, s);
        repeat (5) tick();
`ifdef UART_RX_MAJORITY_EN
        checkOutput("glitch_data", last_valid_data, 8'h00);
`else
        checkOutput("glitch_data", last_valid_data, 8'h08);
`endif

        repeat (10) tick();
        checkOutput("pending_events", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
